// File: rtl/neuron_mac_accumulator_pkg.sv
// Shared types, width helpers and fixed-point constants for the neuron MAC slice.
package neuron_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ACCUM,
      DRAIN,
      BIAS,
      HOLD
   } mac_state_t;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_ADDR_W    = 4;
   localparam int DEF_FRAC_BITS = 4;

   // Accumulator width that cannot overflow for 2**addr_w products plus a bias.
   function automatic int acc_width(input int data_w, input int addr_w);
      return 2 * data_w + addr_w + 1;
   endfunction

   // Largest positive output code.
   function automatic int max_out(input int data_w);
      return (1 << (data_w - 1)) - 1;
   endfunction

endpackage

// File: rtl/neuron_mac_accumulator_if.sv
// Input pair / output neuron handshake bundle.
interface neuron_mac_accumulator_if #(
   parameter int DATA_W = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic signed [DATA_W-1:0] weight;
   logic signed [DATA_W-1:0] bias;
   logic                     out_valid;
   logic                     out_ready;
   logic        [DATA_W-1:0] out_data;
   logic                     sat;
   logic                     busy;

   modport master (
      output in_valid, in_data, weight, bias, out_ready,
      input  in_ready, out_valid, out_data, sat, busy
   );

   modport slave (
      input  in_valid, in_data, weight, bias, out_ready,
      output in_ready, out_valid, out_data, sat, busy
   );
endinterface

// File: rtl/neuron_mac_accumulator_activation.sv
// Fixed-point rescale, ReLU and saturation of the biased accumulator sum.
module neuron_activation
   import neuron_pkg::*;
#(
   parameter int ACC_W     = 21,
   parameter int DATA_W    = 8,
   parameter int FRAC_BITS = 4
) (
   input  logic signed [ACC_W-1:0]  s,
   output logic        [DATA_W-1:0] out_data,
   output logic                     sat
);

   localparam logic signed [ACC_W-1:0] MAX = ACC_W'(max_out(DATA_W));

   logic signed [ACC_W-1:0] r;

   // Arithmetic shift floors toward -inf, then clamp to 0..MAX.
   always_comb begin
      r        = s >>> FRAC_BITS;
      sat      = 1'b0;
      out_data = r[DATA_W-1:0];
      if (r[ACC_W-1]) begin
         out_data = '0;
      end else if (r > MAX) begin
         out_data = MAX[DATA_W-1:0];
         sat      = 1'b1;
      end
   end

endmodule

// File: rtl/neuron_mac_accumulator.sv
// Two-stage multiply-accumulate over 2**ADDR_W pairs, bias add and activation.
module neuron_mac_accumulator
   import neuron_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int FRAC_BITS = DEF_FRAC_BITS,
   parameter int ACC_W     = acc_width(DATA_W, ADDR_W)
) (
   input  logic                  clk,
   input  logic                  reset,
   neuron_mac_accumulator_if.slave bus
);

   localparam int N     = 1 << ADDR_W;
   localparam int CNT_W = (ADDR_W > 0) ? ADDR_W : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   mac_state_t                 state_q;
   logic [CNT_W-1:0]           cnt_q;
   logic signed [2*DATA_W-1:0] prod_q;
   logic                       prod_v_q;
   logic signed [ACC_W-1:0]    acc_q;
   logic signed [DATA_W-1:0]   bias_q;
   logic                       out_valid_q;
   logic [DATA_W-1:0]          out_data_q;
   logic                       sat_q;

   logic                       in_ready;
   logic                       accept;
   logic signed [2*DATA_W-1:0] prod_d;
   logic signed [ACC_W-1:0]    s_d;
   logic [DATA_W-1:0]          act_data;
   logic                       act_sat;

   // Handshake, product and biased sum are pure functions of current state/inputs.
   always_comb begin
      in_ready = (state_q == IDLE) || (state_q == ACCUM);
      accept   = bus.in_valid && in_ready;
      prod_d   = (2*DATA_W)'(bus.in_data) * (2*DATA_W)'(bus.weight);
      s_d      = acc_q + (ACC_W'(bias_q) <<< FRAC_BITS);
   end

   neuron_activation #(
      .ACC_W     (ACC_W),
      .DATA_W    (DATA_W),
      .FRAC_BITS (FRAC_BITS)
   ) u_act (
      .s        (s_d),
      .out_data (act_data),
      .sat      (act_sat)
   );

   // Product pipeline, accumulator and neuron sequencing FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         prod_q      <= '0;
         prod_v_q    <= 1'b0;
         acc_q       <= '0;
         bias_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         sat_q       <= 1'b0;
      end else begin
         prod_v_q <= accept;
         if (accept) prod_q <= prod_d;
         if (prod_v_q) acc_q <= acc_q + ACC_W'(prod_q);

         case (state_q)
            IDLE: begin
               if (accept) begin
                  bias_q  <= bus.bias;
                  cnt_q   <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                  state_q <= (cnt_q == LAST) ? DRAIN : ACCUM;
               end
            end
            ACCUM: begin
               if (accept) begin
                  cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                  if (cnt_q == LAST) state_q <= DRAIN;
               end
            end
            DRAIN: state_q <= BIAS;
            BIAS: begin
               out_data_q  <= act_data;
               sat_q       <= act_sat;
               out_valid_q <= 1'b1;
               state_q     <= HOLD;
            end
            HOLD: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  sat_q       <= 1'b0;
                  acc_q       <= '0;
                  cnt_q       <= '0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.sat       = sat_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Self-checking bench: table-driven frames, corner-case sequences, random frames vs model.
module tb_neuron_mac_accumulator;

   localparam int DATA_W = 8;
   localparam int N      = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   neuron_mac_accumulator_if #(.DATA_W(DATA_W)) bus ();

   neuron_mac_accumulator #(
      .DATA_W    (DATA_W),
      .ADDR_W    (4),
      .FRAC_BITS (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   int fd [N];
   int fw [N];
   int fb;

   typedef struct {
      int din;
      int w;
      int b;
      int exp_out;
      int exp_sat;
   } vec_t;

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: exact integer dot product, floor division by 2**FRAC_BITS, clamp.
   function automatic void model(output int o, output int s);
      longint sum = 0;
      longint r;
      for (int i = 0; i < N; i++) sum += longint'(fd[i]) * longint'(fw[i]);
      sum += longint'(fb) * 16;
      if (sum >= 0) r = sum / 16;
      else          r = -((-sum + 15) / 16);
      s = (r > 127) ? 1 : 0;
      o = (r < 0) ? 0 : ((r > 127) ? 127 : int'(r));
   endfunction

   task automatic wait_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " out_valid"}, bus.out_valid, 0);
      check({tag, " out_data"},  bus.out_data, 0);
      check({tag, " sat"},       bus.sat, 0);
      check({tag, " busy"},      bus.busy, 0);
      check({tag, " in_ready"},  bus.in_ready, 1);
   endtask

   task automatic do_frame(input string tag, input int eo, input int es,
                           input int gapmax, input bit keep_valid, input int hold);
      int lat;
      bus.out_ready = (hold == 0);
      for (int i = 0; i < N; i++) begin
         repeat ($urandom_range(0, gapmax)) begin
            bus.in_valid = 1'b0;
            wait_edge();
         end
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(fd[i]);
         bus.weight   = 8'(fw[i]);
         bus.bias     = (i == 0) ? 8'(fb) : 8'($urandom_range(0, 255));
         check({tag, " in_ready during frame"}, bus.in_ready, 1);
         wait_edge();
      end
      bus.in_valid = keep_valid;
      bus.in_data  = 8'($urandom_range(0, 255));
      bus.weight   = 8'($urandom_range(0, 255));
      bus.bias     = 8'($urandom_range(0, 255));
      lat = 0;
      while (!bus.out_valid && lat < 8) begin
         check({tag, " in_ready after last"}, bus.in_ready, 0);
         wait_edge();
         lat++;
      end
      check({tag, " latency"},  lat, 2);
      check({tag, " out_valid"}, bus.out_valid, 1);
      check({tag, " out_data"},  bus.out_data, eo);
      check({tag, " sat"},       bus.sat, es);
      check({tag, " busy"},      bus.busy, 1);
      check({tag, " in_ready hold"}, bus.in_ready, 0);
      if (hold > 0) begin
         repeat (hold) begin
            wait_edge();
            check({tag, " held out_valid"}, bus.out_valid, 1);
            check({tag, " held out_data"},  bus.out_data, eo);
            check({tag, " held sat"},       bus.sat, es);
            check({tag, " held in_ready"},  bus.in_ready, 0);
         end
         bus.out_ready = 1'b1;
      end
      wait_edge();
      check({tag, " out_valid drop"}, bus.out_valid, 0);
      check({tag, " sat drop"},       bus.sat, 0);
      check({tag, " idle in_ready"},  bus.in_ready, 1);
      check({tag, " idle busy"},      bus.busy, 0);
      check({tag, " out_data kept"},  bus.out_data, eo);
      bus.in_valid = 1'b0;
   endtask

   task automatic fill_const(input int din, input int w, input int b);
      for (int i = 0; i < N; i++) begin
         fd[i] = din;
         fw[i] = w;
      end
      fb = b;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t tbl [7];
      int eo, es;

      tbl[0] = '{din: 1,    w: 16,   b: 0,    exp_out: 16,  exp_sat: 0};
      tbl[1] = '{din: -2,   w: 16,   b: 0,    exp_out: 0,   exp_sat: 0};
      tbl[2] = '{din: 0,    w: 37,   b: 5,    exp_out: 5,   exp_sat: 0};
      tbl[3] = '{din: 127,  w: 127,  b: 127,  exp_out: 127, exp_sat: 1};
      tbl[4] = '{din: -128, w: -128, b: -128, exp_out: 127, exp_sat: 1};
      tbl[5] = '{din: 3,    w: -5,   b: 10,   exp_out: 0,   exp_sat: 0};
      tbl[6] = '{din: 5,    w: 3,    b: 2,    exp_out: 17,  exp_sat: 0};

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.weight    = '0;
      bus.bias      = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      reset = 1'b0;
      wait_edge();

      for (int t = 0; t < 7; t++) begin
         fill_const(tbl[t].din, tbl[t].w, tbl[t].b);
         do_frame($sformatf("table%0d", t), tbl[t].exp_out, tbl[t].exp_sat, 0, 1'b0, 0);
      end

      // Backpressure with in_valid held high, then a clean follow-up frame.
      fill_const(1, 16, 0);
      do_frame("backpressure", 16, 0, 0, 1'b1, 10);
      do_frame("after_bp", 16, 0, 0, 1'b0, 0);

      // Gapped input; bias randomised after element 0.
      do_frame("gapped", 16, 0, 5, 1'b0, 0);

      // Asynchronous reset after 7 accepts.
      for (int i = 0; i < 7; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 8'(1);
         bus.weight   = 8'(16);
         bus.bias     = 8'(0);
         wait_edge();
      end
      check("midframe busy", bus.busy, 1);
      #2;
      reset = 1'b1;
      #1;
      check_reset_state("async reset");
      bus.in_valid = 1'b0;
      wait_edge();
      reset = 1'b0;
      wait_edge();
      do_frame("after_reset", 16, 0, 0, 1'b0, 0);

      // Random frames against the reference model.
      for (int f = 0; f < 25; f++) begin
         for (int i = 0; i < N; i++) begin
            fd[i] = int'($urandom_range(0, 255)) - 128;
            fw[i] = int'($urandom_range(0, 255)) - 128;
         end
         fb = int'($urandom_range(0, 255)) - 128;
         model(eo, es);
         do_frame($sformatf("rand%0d", f), eo, es, 2, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
